bp_update_sched: RTL

BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

---
 rtl/bp_sched_pkg.sv | 22 ++
 rtl/bp_update_fifo.sv | 59 +++++
 rtl/bp_update_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bp_sched_pkg.sv
// rtl/bp_sched_pkg.sv - shared types for the branch-predictor update scheduler
// Purpose : scheduler state enum and the queued update entry.
// Contents: sched_state_t (RUN, DRAIN, CLEAR)
//           upd_entry_t   {pc, taken}; ENTRY_PC_BITS bounds the PC width
package bp_sched_pkg;

   // Widest branch PC an update entry can carry; PC_BITS of the scheduler
   // must not exceed this.
   localparam int ENTRY_PC_BITS = 32;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic [ENTRY_PC_BITS-1:0] pc;
      logic                     taken;
   } upd_entry_t;

endpackage

// File: rtl/bp_update_fifo.sv
// rtl/bp_update_fifo.sv - in-order update queue with empty-queue fall-through
// Purpose : holds accepted updates in accept order.
// Ports   : clk, rst         clock, async active-high reset
//           push, push_data  write side
//           pop, pop_data    read side; pop_data shows push_data when empty
//           full, empty      occupancy flags
//           count            entries held, 0..DEPTH
module bp_update_fifo
   import bp_sched_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  upd_entry_t       push_data,
   input  logic             pop,
   output upd_entry_t       pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   upd_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             bypass;
   logic             do_push;
   logic             do_pop;

   assign empty  = (count == '0);
   assign full   = (count == CNT_W'(DEPTH));
   // Push and pop together on an empty queue hands the entry straight
   // through, so an update issues the cycle after it is accepted.
   assign bypass   = empty && push && pop;
   assign do_push  = push && !full && !bypass;
   assign do_pop   = pop && !empty;
   assign pop_data = empty ? push_data : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - arbitrates branch-resolution updates and table clears
// Purpose : round-robin accepts one update per cycle into an in-order queue,
//           issues one update per cycle to the predictor, and on clear_req
//           drains the queue then zeroes every table line.
// Ports   : clk, rst                              clock, async active-high reset
//           req_valid, req_pc, req_taken, req_ready  N_REQ requester ports
//           clear_req, clear_busy                 clear request / in progress
//           upd_wr_en, upd_orig_pc, upd_is_taken  predictor update port
//           clr_wr_en, clr_addr                   line-clear port
module bp_update_sched
   import bp_sched_pkg::*;
#(
   parameter  int PC_BITS  = 32,
   parameter  int SIZE     = 1024,
   parameter  int N_REQ    = 2,
   parameter  int Q_DEPTH  = 4,
   localparam int SEL_BITS = $clog2(SIZE)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*PC_BITS-1:0] req_pc,
   input  logic [N_REQ-1:0]         req_taken,
   output logic [N_REQ-1:0]         req_ready,
   input  logic                     clear_req,
   output logic                     clear_busy,
   output logic                     upd_wr_en,
   output logic [PC_BITS-1:0]       upd_orig_pc,
   output logic                     upd_is_taken,
   output logic                     clr_wr_en,
   output logic [SEL_BITS-1:0]      clr_addr
);

   localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(Q_DEPTH) + 1;

   sched_state_t        state;
   sched_state_t        state_nxt;
   logic [RR_W-1:0]     rr_ptr;
   logic [SEL_BITS-1:0] clr_cnt;
   logic                gnt_found;
   logic [RR_W-1:0]     gnt_idx;
   logic                accept;
   logic                pop;
   upd_entry_t          push_entry;
   upd_entry_t          pop_entry;
   logic                q_full;
   logic                q_empty;
   logic [CNT_W-1:0]    q_count;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      int k;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      k         = 0;
      for (int i = 0; i < N_REQ; i++) begin
         k = int'(rr_ptr) + i;
         if (k >= N_REQ) k = k - N_REQ;
         if (!gnt_found && req_valid[k]) begin
            gnt_found = 1'b1;
            gnt_idx   = RR_W'(k);
         end
      end
   end

   // A full queue refuses even if it pops this cycle.
   assign accept = gnt_found && (state == RUN) && !q_full;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[gnt_idx] = 1'b1;
   end

   assign push_entry.pc    = ENTRY_PC_BITS'(req_pc[gnt_idx*PC_BITS +: PC_BITS]);
   assign push_entry.taken = req_taken[gnt_idx];

   assign pop = ((state == RUN) || (state == DRAIN)) && (!q_empty || accept);

   bp_update_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (pop_entry),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RUN;
         rr_ptr       <= '0;
         clr_cnt      <= '0;
         upd_wr_en    <= 1'b0;
         upd_orig_pc  <= '0;
         upd_is_taken <= 1'b0;
      end else begin
         state     <= state_nxt;
         upd_wr_en <= pop;
         if (pop) begin
            upd_orig_pc  <= PC_BITS'(pop_entry.pc);
            upd_is_taken <= pop_entry.taken;
         end
         if (accept) begin
            rr_ptr <= (gnt_idx == RR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         end
         // Counter only advances inside CLEAR, so it always enters at 0.
         clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         RUN:     if (clear_req) state_nxt = DRAIN;
         // Wait for the queue and the last issued update to be gone.
         DRAIN:   if ((q_count == '0) && !upd_wr_en) state_nxt = CLEAR;
         CLEAR:   if (clr_cnt == SEL_BITS'(SIZE - 1)) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   assign clr_wr_en  = (state == CLEAR);
   assign clr_addr   = clr_cnt;
   assign clear_busy = (state != RUN);

endmodule
